lb_reg_slave: RTL

LB_REG_SLAVE -- requirements
Module: lb_reg_slave

---
 rtl/lb_reg_slave.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/lb_reg_slave.sv
// lb_reg_slave: local-bus register slave with a fixed-latency read path.
// Register map (byte offsets): 0x00 VERSION, 0x04 SCRATCH0, 0x08 SCRATCH1,
// 0x0C CTRL[7:0], 0x10 STATUS (W1C, [0]=bad write, [1]=dropped read),
// 0x14 TICK, 0x18 WR_CNT.
// Optional build macro LB_SLV_BADADDR_EN: unmapped/non-hit reads return
// 32'hDEAD_BEEF instead of 0.
module lb_reg_slave #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          RD_LAT    = 2,
  parameter logic [31:0] VERSION   = 32'h2023_0220
) (
  input  logic        S_LB_CLK,
  input  logic        S_LB_RST,
  input  logic        S_LB_WREQ,
  input  logic [15:0] S_LB_WADDR,
  input  logic [31:0] S_LB_WDATA,
  input  logic        S_LB_RREQ,
  input  logic [15:0] S_LB_RADDR,
  output logic [31:0] S_LB_RDATA,
  output logic        S_LB_RFINISH,
  output logic [7:0]  CTRL_OUT
);

`ifdef LB_SLV_BADADDR_EN
  localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] BAD_DATA = 32'h0000_0000;
`endif

  // Number of extra WAIT cycles after the first one; unused when RD_LAT is 1.
  localparam logic [3:0] WAIT_INIT = (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [31:0] scratch0_q;
  logic [31:0] scratch1_q;
  logic [7:0]  ctrl_q;
  logic [1:0]  status_q;
  logic [1:0]  status_d;
  logic [31:0] tick_q;
  logic [31:0] wrCnt_q;

  state_t      state_q;
  logic [3:0]  waitCnt_q;
  logic [31:0] capture_q;
  logic [31:0] rdata_q;
  logic        rfinish_q;

  logic        wrHit;
  logic        rdHit;
  logic [3:0]  wrIdx;
  logic [3:0]  rdIdx;
  logic        wrGood;
  logic        wrBad;
  logic        rdIgnored;
  logic [31:0] rdValue;

  // Byte-lane bits of the addresses are deliberately not decoded.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{S_LB_WADDR[1:0], S_LB_RADDR[1:0]};

  assign wrHit     = (S_LB_WADDR[15:6] == BASE_ADDR[15:6]);
  assign rdHit     = (S_LB_RADDR[15:6] == BASE_ADDR[15:6]);
  assign wrIdx     = S_LB_WADDR[5:2];
  assign rdIdx     = S_LB_RADDR[5:2];

  // Only SCRATCH0/1, CTRL and STATUS accept writes; everything else is flagged.
  assign wrGood    = S_LB_WREQ && wrHit &&
                     (wrIdx == 4'd1 || wrIdx == 4'd2 || wrIdx == 4'd3 || wrIdx == 4'd4);
  assign wrBad     = S_LB_WREQ && !wrGood;
  assign rdIgnored = S_LB_RREQ && (state_q != IDLE);

  // Read mux sees current register values, so a same-cycle write is not visible.
  always_comb begin
    rdValue = BAD_DATA;
    if (rdHit) begin
      case (rdIdx)
        4'd0:    rdValue = VERSION;
        4'd1:    rdValue = scratch0_q;
        4'd2:    rdValue = scratch1_q;
        4'd3:    rdValue = {24'h0, ctrl_q};
        4'd4:    rdValue = {30'h0, status_q};
        4'd5:    rdValue = tick_q;
        4'd6:    rdValue = wrCnt_q;
        default: rdValue = BAD_DATA;
      endcase
    end
  end

  // STATUS next state: W1C clear first, then hardware sets override it.
  always_comb begin
    status_d = status_q;
    if (wrGood && wrIdx == 4'd4) begin
      status_d = status_q & ~S_LB_WDATA[1:0];
    end
    if (wrBad) begin
      status_d[0] = 1'b1;
    end
    if (rdIgnored) begin
      status_d[1] = 1'b1;
    end
  end

  // Writable registers, status, free-running tick and saturating write counter.
  always_ff @(posedge S_LB_CLK or posedge S_LB_RST) begin
    if (S_LB_RST) begin
      scratch0_q <= 32'h0;
      scratch1_q <= 32'h0;
      ctrl_q     <= 8'h0;
      status_q   <= 2'b00;
      tick_q     <= 32'h0;
      wrCnt_q    <= 32'h0;
    end else begin
      status_q <= status_d;
      tick_q   <= tick_q + 32'd1;
      if (wrGood) begin
        case (wrIdx)
          4'd1:    scratch0_q <= S_LB_WDATA;
          4'd2:    scratch1_q <= S_LB_WDATA;
          4'd3:    ctrl_q     <= S_LB_WDATA[7:0];
          default: ;
        endcase
        if (wrCnt_q != 32'hFFFF_FFFF) begin
          wrCnt_q <= wrCnt_q + 32'd1;
        end
      end
    end
  end

  // Read FSM: capture at request, present data and a one-cycle finish in DONE.
  always_ff @(posedge S_LB_CLK or posedge S_LB_RST) begin
    if (S_LB_RST) begin
      state_q   <= IDLE;
      waitCnt_q <= 4'd0;
      capture_q <= 32'h0;
      rdata_q   <= 32'h0;
      rfinish_q <= 1'b0;
    end else begin
      rfinish_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (S_LB_RREQ) begin
            capture_q <= rdValue;
            if (RD_LAT == 1) begin
              state_q   <= DONE;
              rfinish_q <= 1'b1;
              rdata_q   <= rdValue;
            end else begin
              state_q   <= WAIT;
              waitCnt_q <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (waitCnt_q == 4'd0) begin
            state_q   <= DONE;
            rfinish_q <= 1'b1;
            rdata_q   <= capture_q;
          end else begin
            waitCnt_q <= waitCnt_q - 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign S_LB_RDATA   = rdata_q;
  assign S_LB_RFINISH = rfinish_q;
  assign CTRL_OUT     = ctrl_q;

endmodule
